// File: rtl/generic_fifo_sc_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// quartile level, sticky error flags. Define GENERIC_FIFO_FWFT_EN for first-word-fall-through.
module generic_fifo_sc_prog #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] din,
    input  logic          we,
    input  logic          re,
    input  logic [AW:0]   af_thr,
    input  logic [AW:0]   ae_thr,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   cnt,
    output logic [1:0]    level,
    output logic          ovf,
    output logic          unf
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
    localparam logic [AW:0] LVL_Q3 = (AW+1)'(3 << (AW-2));
    localparam logic [AW:0] LVL_H  = (AW+1)'(1 << (AW-1));
    localparam logic [AW:0] LVL_Q1 = (AW+1)'(1 << (AW-2));

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          rd_ok, wr_ok;

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    always_comb begin
        rd_ok = re && (cnt_q != '0);
        wr_ok = we && ((cnt_q != DEPTH) || rd_ok);
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clr) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (wr_ok) wp_d = wp_q + 1'b1;
            if (rd_ok) rp_d = rp_q + 1'b1;
            if (wr_ok && !rd_ok) cnt_d = cnt_q + 1'b1;
            else if (rd_ok && !wr_ok) cnt_d = cnt_q - 1'b1;
            if (we && !wr_ok) ovf_d = 1'b1;
            if (re && !rd_ok) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage has no reset; only accepted writes outside reset/clear land in it.
    always_ff @(posedge clk) begin
        if (rst && !clr && wr_ok) mem_q[wp_q] <= din;
    end

`ifdef GENERIC_FIFO_FWFT_EN
    assign dout = mem_q[rp_q];
`else
    logic [DW-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (!clr && rd_ok) dout_d = mem_q[rp_q];
    end

    always_ff @(posedge clk) begin
        if (!rst) dout_q <= '0;
        else      dout_q <= dout_d;
    end

    assign dout = dout_q;
`endif

    assign cnt          = cnt_q;
    assign ovf          = ovf_q;
    assign unf          = unf_q;
    assign full         = (cnt_q == DEPTH);
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= af_thr);
    assign almost_empty = (cnt_q <= ae_thr);

    always_comb begin
        if (cnt_q >= LVL_Q3)      level = 2'd3;
        else if (cnt_q >= LVL_H)  level = 2'd2;
        else if (cnt_q >= LVL_Q1) level = 2'd1;
        else                      level = 2'd0;
    end

endmodule

// File: tb/tb_generic_fifo_sc_prog.sv
// Self-checking bench for generic_fifo_sc_prog (DW=8, AW=4): vector table plus
// reference queue model with scoreboard on the read data.
module tb_generic_fifo_sc_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] din = '0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic [4:0] af_thr = 5'd12;
    logic [4:0] ae_thr = 5'd2;
    logic [7:0] dout;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] cnt;
    logic [1:0] level;
    logic       ovf, unf;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] m_dout = '0;

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] d;
        int         cnt;
        logic       ovf;
        logic [1:0] lvl;
        logic       ae;
        logic       af;
        logic       full;
    } vec_t;

    vec_t tbl[38];

    generic_fifo_sc_prog #(.DW(8), .AW(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re),
        .af_thr(af_thr), .ae_thr(ae_thr), .dout(dout), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .cnt(cnt),
        .level(level), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] lvl_of(input int c);
        if (c >= 12) return 2'd3;
        if (c >= 8) return 2'd2;
        if (c >= 4) return 2'd1;
        return 2'd0;
    endfunction

    function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d,
                                input int c, input logic o);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.cnt = c; v.ovf = o;
        v.lvl = lvl_of(c);
        v.ae = (c <= 2);
        v.af = (c >= 12);
        v.full = (c == 16);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int n;
        n = m_q.size();
        chk("cnt", 32'(cnt), 32'(n));
        chk("full", 32'(full), 32'(n == 16));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("level", 32'(level), 32'(lvl_of(n)));
        chk("almost_full", 32'(almost_full), 32'(n >= 12));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("unf", 32'(unf), 32'(m_unf));
    endtask

    // One clock of stimulus; the expected read word is queued when the read is driven.
    task automatic step(input logic w, input logic r, input logic [7:0] d,
                        input logic c, input logic rn);
        logic rd, wr;
        logic [7:0] got;
        we = w; re = r; din = d; clr = c; rst = rn;
        rd = rn && !c && r && (m_q.size() > 0);
        wr = rn && !c && w && ((m_q.size() < 16) || rd);
        if (rd) exp_q.push_back(m_q[0]);
`ifdef GENERIC_FIFO_FWFT_EN
        #1;
        if (rd) begin
            got = exp_q.pop_front();
            chk("fwft_dout", 32'(dout), 32'(got));
        end
`endif
        @(posedge clk);
        #1;
        if (!rn) begin
            m_q.delete();
            exp_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_dout = '0;
        end else if (c) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (rd) void'(m_q.pop_front());
            if (wr) m_q.push_back(d);
            if (w && !wr) m_ovf = 1'b1;
            if (r && !rd) m_unf = 1'b1;
        end
`ifndef GENERIC_FIFO_FWFT_EN
        if (rd) m_dout = exp_q.pop_front();
        chk("dout", 32'(dout), 32'(m_dout));
`endif
        check_state();
    endtask

    initial begin
        for (int i = 0; i < 17; i++)
            tbl[i] = mk(1'b1, 1'b0, (i < 16) ? 8'(i) : 8'hFF, (i < 16) ? i + 1 : 16, i == 16);
        for (int i = 0; i < 5; i++)
            tbl[17 + i] = mk(1'b1, 1'b1, 8'(8'h10 + i), 16, 1'b1);
        for (int i = 0; i < 16; i++)
            tbl[22 + i] = mk(1'b0, 1'b1, 8'h00, 15 - i, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        check_state();
`ifndef GENERIC_FIFO_FWFT_EN
        chk("reset_dout", 32'(dout), 32'h0);
`endif
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Fill, overflow, full pass-through, then drain through the quartile boundaries.
        for (int i = 0; i < 38; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].d, 1'b0, 1'b1);
            chk("tbl_cnt", 32'(cnt), 32'(tbl[i].cnt));
            chk("tbl_ovf", 32'(ovf), 32'(tbl[i].ovf));
            chk("tbl_level", 32'(level), 32'(tbl[i].lvl));
            chk("tbl_ae", 32'(almost_empty), 32'(tbl[i].ae));
            chk("tbl_af", 32'(almost_full), 32'(tbl[i].af));
            chk("tbl_full", 32'(full), 32'(tbl[i].full));
        end

        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("clr_ovf", 32'(ovf), 32'h0);

        // Simultaneous read/write on an empty FIFO: write only, underflow flagged.
        step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b1);
        chk("empty_rw_cnt", 32'(cnt), 32'd1);
        chk("empty_rw_unf", 32'(unf), 32'h1);
`ifdef GENERIC_FIFO_FWFT_EN
        chk("fwft_a5_ready", 32'(dout), 32'hA5);
`endif
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        chk("a5_read", 32'(cnt), 32'd0);
`ifndef GENERIC_FIFO_FWFT_EN
        chk("a5_dout", 32'(dout), 32'hA5);
`endif
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 1'b0, 1'b1);

        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        chk("pre_clr_cnt", 32'(cnt), 32'd8);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
        chk("clr_cnt", 32'(cnt), 32'd0);
        chk("clr_empty", 32'(empty), 32'h1);

        // Reset in the middle of a write burst.
        for (int i = 0; i < 5; i++)
            step(1'b1, i[0], 8'(8'h60 + i), 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'h1);
        chk("mid_rst_ae", 32'(almost_empty), 32'h1);
`ifndef GENERIC_FIFO_FWFT_EN
        chk("mid_rst_dout", 32'(dout), 32'h0);
`endif
        step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'hC3, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
